// File: rtl/shift_sequencer.sv
// shift_sequencer: request front-end for the serial left-only shifter.
// Right shifts are folded onto left-shift hardware by bit-reversing the
// operand on the way in and the result on the way out. Arithmetic right
// shifts of negative values additionally invert both, so the shifter's
// zero fill becomes a one fill after the final inversion.
module shift_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_funct,
  input  logic [31:0] i_operand,
  input  logic [4:0]  i_shamt,
  input  logic        i_flush,
  output logic        o_sh_start,
  output logic [31:0] o_sh_op1,
  output logic [4:0]  o_sh_op2,
  input  logic [31:0] i_sh_result,
  input  logic        i_sh_done,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA} op_t;

  state_t      state;
  op_t         op_q;
  logic        sign_q;
  op_t         req_op;
  logic [31:0] pre_operand;
  logic [31:0] post_result;

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  assign o_ready = (state == IDLE) && !i_flush;
  assign o_busy  = (state != IDLE);

  // Decode the incoming request and condition its operand for the shifter.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    req_op      = OP_SLL;
    pre_operand = i_operand;
    case (i_funct)
      2'b01: begin
        req_op      = OP_SRL;
        pre_operand = bitrev(i_operand);
      end
      2'b11: begin
        req_op      = OP_SRA;
        pre_operand = bitrev(i_operand[31] ? ~i_operand : i_operand);
      end
      default: ;
    endcase
  end

  // Undo the operand conditioning on the shifter's result.
  always_comb begin
    post_result = i_sh_result;
    case (op_q)
      OP_SRL:  post_result = bitrev(i_sh_result);
      OP_SRA:  post_result = bitrev(i_sh_result) ^ {32{sign_q}};
      default: ;
    endcase
  end

  // Request sequencing: issue, wait for the shifter, hold the response.
  // NOTE: the reset branch is asynchronous (in the sensitivity list) and
  // all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      op_q       <= OP_SLL;
      sign_q     <= 1'b0;
      o_sh_start <= 1'b0;
      o_sh_op1   <= '0;
      o_sh_op2   <= '0;
      o_result   <= '0;
      o_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            op_q       <= req_op;
            sign_q     <= i_operand[31];
            o_sh_op1   <= pre_operand;
            o_sh_op2   <= i_shamt;
            o_sh_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // The shifter has seen start by now, so a flush must still drain.
          o_sh_start <= 1'b0;
          state      <= i_flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (i_sh_done) begin
            if (i_flush) begin
              state <= IDLE;
            end else begin
              o_result <= post_result;
              o_valid  <= 1'b1;
              state    <= RESP;
            end
          end else if (i_flush) begin
            state <= DRAIN;
          end
        end
        RESP: begin
          if (i_flush || i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        DRAIN: begin
          // The shifter cannot be aborted; swallow its result.
          if (i_sh_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Request front-end for the serial left-only shifter in the execute stage. It accepts shift requests (SLL/SRL/SRA) over a valid/ready handshake and pre-conditions the operand so right shifts can run on left-shift hardware. It issues a one-cycle start pulse to the shifter, waits for its done pulse, post-conditions the result, and holds it on a valid/ready output until consumed.

## Interface
- No parameters; all datapaths fixed at 32 bits, shift amount 5 bits.
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready at a rising edge
- i_funct  in  2  00 SLL, 01 SRL, 11 SRA, 10 treated as SLL
- i_operand  in  32  value to shift
- i_shamt  in  5  shift amount 0..31
- i_flush  in  1  synchronous abort of in-flight request
- o_sh_start  out  1  start pulse to shifter (registered)
- o_sh_op1  out  32  conditioned operand to shifter (registered)
- o_sh_op2  out  5  shift amount to shifter (registered)
- i_sh_result  in  32  shifter result, valid when i_sh_done=1
- i_sh_done  in  1  shifter completion pulse, one cycle
- o_valid  out  1  result valid
- i_ready  in  1  consumer takes result when o_valid && i_ready at a rising edge
- o_result  out  32  final shift result
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN. Reset -> IDLE.
- o_ready = (state == IDLE) && !i_flush.
- IDLE: on accept, latch funct and shamt; load o_sh_op1 = pre(i_operand), o_sh_op2 = i_shamt, o_sh_start = 1; -> ISSUE.
- pre(x): SLL: x. SRL: bitrev(x). SRA: bitrev(x[31] ? ~x : x).
- ISSUE (exactly one cycle, o_sh_start = 1): -> WAIT; o_sh_start cleared on leaving. If i_flush -> DRAIN.
- WAIT: on i_sh_done, o_result = post(i_sh_result), o_valid = 1, -> RESP. If i_flush without i_sh_done -> DRAIN; i_flush with i_sh_done -> IDLE, result discarded.
- post(r): SLL: r. SRL: bitrev(r). SRA: sign latched from operand bit 31; bitrev(r), inverted if sign was 1.
- RESP: hold o_result and o_valid stable until i_ready; on handshake clear o_valid -> IDLE. i_flush -> clear o_valid, -> IDLE.
- DRAIN: wait for i_sh_done (shifter cannot be aborted), discard result, -> IDLE. i_flush ignored here.
- i_sh_done in IDLE, ISSUE or RESP is ignored (no state or output change).
- o_sh_op1/o_sh_op2 hold their last values after ISSUE; only o_sh_start returns to 0.
- Arithmetic: all results are mod 2^32; shamt 0 returns operand unchanged for all functs; SRA of negative by 31 gives 0xFFFFFFFF.

## Timing
- Reset values: o_sh_start 0, o_sh_op1 0, o_sh_op2 0, o_result 0, o_valid 0, o_busy 0; o_ready 1 after reset deassertion (when i_flush = 0).
- Async reset mid-operation returns to IDLE immediately; the shifter shares i_rst_n, so no drain is needed.
- Edge numbering: accept at edge 0; o_sh_start high between edges 0 and 1.
- The shifter sees start at edge 1 and raises done after edge 1+n, for shamt n.
- o_valid rises after edge 2+n: latency n+2 cycles from accept. SLL by 0 gives o_valid after edge 2.
- Throughput: next accept no earlier than the edge after the result handshake; o_ready is low for the whole RESP state.
- Only one request is outstanding at the shifter; o_sh_start is never reasserted before the previous done has been consumed in WAIT or DRAIN.

## Test plan
- SLL: operand 0x00000001, shamt 4 -> o_result 0x00000010; o_valid rises 6 cycles after accept; single o_sh_start pulse.
- SRL and SRA: operand 0x80000000, shamt 31 -> SRL 0x00000001, SRA 0xFFFFFFFF. Operand 0xF0F0F0F0, shamt 4, SRA -> 0xFF0F0F0F.
- Zero shift and backpressure: SRA 0x12345678 by 0 -> 0x12345678 after 2 cycles. Hold i_ready low for 5 cycles -> o_result stable and o_ready low; handshake -> o_ready high next cycle.
- Flush in WAIT: SLL by 20, flush 3 cycles after accept -> DRAIN; no o_valid; o_ready returns the cycle after i_sh_done. A new SLL 0x3 by 1 then returns 0x6.
- Flush in RESP, and spurious i_sh_done pulses in IDLE -> o_valid drops, no new result, state stays IDLE.
- Async reset asserted in WAIT -> all outputs return to reset values immediately; after release, a fresh SRL 0x100 by 8 -> 0x1.
